// File: rtl/cam_hit_fifo.sv
// First-word-fall-through queue of CAM hit addresses with occupancy and sticky overflow.
// Optional CAM_HIT_FIFO_STATS_EN adds a saturating drop_count output.
module cam_hit_fifo #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hit_in,
  input  logic [ADDR_WIDTH-1:0] hit_addr_in,
  input  logic                  out_ready,
  input  logic                  clear_overflow,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [PTR_WIDTH:0]    fifo_count,
  output logic                  full,
  output logic                  empty,
`ifdef CAM_HIT_FIFO_STATS_EN
  output logic [7:0]            drop_count,
`endif
  output logic                  overflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_reg;
  logic [PTR_WIDTH-1:0]  wr_ptr_reg;
  logic [PTR_WIDTH:0]    count_reg;
  logic                  overflow_reg;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == DEPTH_CNT);
  assign out_valid  = !empty;
  assign out_addr   = empty ? '0 : mem[rd_ptr_reg];
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

  // A pop on a full queue frees the slot the simultaneous push lands in.
  assign pop  = out_valid && out_ready;
  assign push = hit_in && (!full || pop);
  assign drop = hit_in && full && !pop;

  // Storage is deliberately not reset; count gates visibility of stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= hit_addr_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

`ifdef CAM_HIT_FIFO_STATS_EN
  logic [7:0] drop_count_reg;

  assign drop_count = drop_count_reg;

  // A drop in the clearing cycle restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_reg <= '0;
    end else if (drop) begin
      if (clear_overflow) begin
        drop_count_reg <= 8'd1;
      end else if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end else if (clear_overflow) begin
      drop_count_reg <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_cam_hit_fifo.sv
// Scoreboard bench for cam_hit_fifo: stimulus queues expected addresses, a negedge monitor
// compares every head entry that is handed over to the consumer.
module tb_cam_hit_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hit_in = 1'b0;
  logic [7:0] hit_addr_in = '0;
  logic       out_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       out_valid;
  logic [7:0] out_addr;
  logic [3:0] fifo_count;
  logic       full;
  logic       empty;
  logic       overflow;
`ifdef CAM_HIT_FIFO_STATS_EN
  logic [7:0] drop_count;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  cam_hit_fifo #(.ADDR_WIDTH(8), .DEPTH(8), .PTR_WIDTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .hit_in(hit_in),
    .hit_addr_in(hit_addr_in),
    .out_ready(out_ready),
    .clear_overflow(clear_overflow),
    .out_valid(out_valid),
    .out_addr(out_addr),
    .fifo_count(fifo_count),
    .full(full),
    .empty(empty),
`ifdef CAM_HIT_FIFO_STATS_EN
    .drop_count(drop_count),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; returns #1 after the active edge.
  task automatic cycle(input logic hit, input logic [7:0] addr, input logic rdy, input logic clr);
    hit_in = hit;
    hit_addr_in = addr;
    out_ready = rdy;
    clear_overflow = clr;
    @(posedge clk);
    #1;
    hit_in = 1'b0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] addr);
    exp_q.push_back(addr);
    cycle(1'b1, addr, 1'b0, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_addr"}, 32'(out_addr), 32'd0);
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", out_addr);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("pop 0x%02h expected 0x%02h", out_addr, e);
        if (out_addr !== e) begin
          mismatched++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_addr, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_idle("reset");
    chk("reset_ovf", 32'(overflow), 32'd0);
`ifdef CAM_HIT_FIFO_STATS_EN
    chk("reset_drops", 32'(drop_count), 32'd0);
`endif

    // Single entry latency and pop.
    push_exp(8'h03);
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_addr", 32'(out_addr), 32'h03);
    chk("one_count", 32'(fifo_count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("one_empty", 32'(empty), 32'd1);
    chk("one_addr0", 32'(out_addr), 32'h00);

    // Fill/drain twice; write pointer starts at 1 so both pointers wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) push_exp(8'(i));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(fifo_count), 32'd8);
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_empty", 32'(empty), 32'd1);
    end

    // Drop on full queue.
    for (int i = 0; i < 8; i++) push_exp(8'h10 + 8'(i));
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count8", 32'(fifo_count), 32'd8);
`ifdef CAM_HIT_FIFO_STATS_EN
    chk("drop_drops", 32'(drop_count), 32'd1);
`endif
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
`ifdef CAM_HIT_FIFO_STATS_EN
    chk("clr_drops", 32'(drop_count), 32'd0);
`endif

    // Full with simultaneous push and pop: accepted, no overflow.
    exp_q.push_back(8'hAA);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("pp_count", 32'(fifo_count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_empty", 32'(empty), 32'd1);

    // Drop and clear together: set wins.
    for (int i = 0; i < 8; i++) push_exp(8'h20 + 8'(i));
    cycle(1'b1, 8'h66, 1'b0, 1'b1);
    chk("setwin_ovf", 32'(overflow), 32'd1);
`ifdef CAM_HIT_FIFO_STATS_EN
    chk("setwin_drops", 32'(drop_count), 32'd1);
`endif
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr2_ovf", 32'(overflow), 32'd0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("drop2_ovf", 32'(overflow), 32'd1);

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    #2 reset = 1'b1;
    #1;
    check_idle("async_rst");
    chk("async_rst_ovf", 32'(overflow), 32'd0);
`ifdef CAM_HIT_FIFO_STATS_EN
    chk("async_rst_drops", 32'(drop_count), 32'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // Ready while empty is a no-op; then normal traffic resumes.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rdy_empty_count", 32'(fifo_count), 32'd0);
    push_exp(8'h42);
    chk("post_addr", 32'(out_addr), 32'h42);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_empty", 32'(empty), 32'd1);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
